bus_6502: RTL and testbench
===========================

BUS_6502 -- requirements
Module: bus_6502

Interface
REQ-001 Parameter AW, default 16, address width of the core and memory bus.
REQ-002 Parameter DW, default 8, data width of the core and memory bus.
REQ-003 Port eclk  input  1  system clock; all state is clocked on its rising edge.
REQ-004 Port ereset_n  input  1  asynchronous active-low reset.
REQ-005 Port clk0  input  1  6502 phase clock from the clock generator; synchronous to eclk, high = phi2.
REQ-006 Port res  input  1  core reset, active low; the core runs when res=1.
REQ-007 Port ab  input  AW  core address bus.
REQ-008 Port rw  input  1  core read/write strobe, 1 = read.
REQ-009 Port db_out  input  DW  core write data.
REQ-010 Port db_in  output  DW  read data returned to the core.
REQ-011 Port mem_req  output  1  memory request.
REQ-012 Port mem_we  output  1  memory write enable, valid while mem_req=1.
REQ-013 Port mem_addr  output  AW  memory address, valid while mem_req=1.
REQ-014 Port mem_wdata  output  DW  memory write data, valid while mem_req=1.
REQ-015 Port mem_ack  input  1  memory acknowledge, one-eclk pulse; mem_rdata is valid in the same cycle.
REQ-016 Port mem_rdata  input  DW  memory read data.
REQ-017 Port cycle_cnt  output  32  count of core bus cycles issued.
REQ-018 Port overrun  output  1  sticky flag: an access was not acknowledged before clk0 fell.
REQ-019 Port drop_cnt  output  8  count of dropped bus cycles; saturates at 255.

Function
REQ-020 The block SHALL detect clk0 rise and fall by comparing clk0 with a one-eclk registered copy; each edge is seen one eclk after it occurs.
REQ-021 The block SHALL implement a three-state FSM: IDLE, WAIT_ACK and DONE.
REQ-022 IDLE to WAIT_ACK: on a clk0 rise with res=1, capture ab into mem_addr, ~rw into mem_we and db_out into mem_wdata, set mem_req=1, and increment cycle_cnt (32-bit, wraps).
REQ-023 WAIT_ACK: hold mem_req and all mem_* outputs stable until mem_ack is sampled high.
REQ-024 WAIT_ACK with mem_ack on a read: load db_in from mem_rdata; clear mem_req on the next edge; go to DONE.
REQ-025 WAIT_ACK with mem_ack on a write: leave db_in unchanged; clear mem_req; go to DONE.
REQ-026 DONE to IDLE on a clk0 fall; db_in holds its value until the next read acknowledge.
REQ-027 A clk0 fall in WAIT_ACK without mem_ack SHALL set overrun; the FSM stays in WAIT_ACK, and after mem_ack it goes directly to IDLE.
REQ-028 A clk0 fall and mem_ack in the same eclk SHALL count as an acknowledge: no overrun, and the FSM goes to IDLE.
REQ-029 A clk0 rise while not in IDLE SHALL start no access and SHALL increment drop_cnt, saturating at 255; cycle_cnt is unchanged.
REQ-030 A clk0 rise with res=0 SHALL start no access and change no counters.
REQ-031 res falling mid-access SHALL NOT abort the handshake: mem_req stays high until mem_ack.
REQ-032 mem_req SHALL never be high for more than one access at a time, and SHALL be low for at least one eclk between accesses.

Reset
REQ-033 On ereset_n=0, asynchronously: FSM=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, db_in=0, cycle_cnt=0, drop_cnt=0, overrun=0, and the clk0 delay register=0.
REQ-034 overrun SHALL clear only on reset.

Structure
REQ-035 A shared package pkg_6502 SHALL hold the FSM state enum (IDLE, WAIT_ACK, DONE) and the default AW and DW constants.
REQ-036 Edge detection SHALL be in one sub-module, clk0_edge (outputs rise and fall pulses), instantiated once.

Verification
REQ-037 Read: res=1, ab=16'hFFFC, rw=1, mem_ack 3 eclk after mem_req, mem_rdata=8'h34 -> mem_addr=FFFC, mem_we=0, db_in=34, cycle_cnt=1, overrun=0.
REQ-038 Write: ab=16'h0200, rw=0, db_out=8'hA5, ack after 2 eclk -> mem_we=1, mem_wdata=A5, db_in unchanged, FSM in IDLE after the clk0 fall.
REQ-039 Late ack: ack withheld past the clk0 fall -> overrun=1; the next clk0 rise, still in WAIT_ACK, gives drop_cnt=1; after the ack the next rise issues normally.
REQ-040 Same-cycle edge: mem_ack in the same eclk as the detected clk0 fall -> overrun=0, FSM in IDLE.
REQ-041 Reset: ereset_n pulsed low mid-WAIT_ACK -> all outputs zero immediately, without waiting for eclk; res=0 for 10 clk0 periods -> no mem_req, cycle_cnt=0.
REQ-042 Saturation: force 300 drops -> drop_cnt=255; preload cycle_cnt to 32'hFFFFFFFF, issue one access -> cycle_cnt=0.

Source files
------------

// File: rtl/bus_6502_pkg.sv
// Shared definitions for the 6502 bus bridge.
//   state_t : bridge FSM states (IDLE, WAIT_ACK, DONE)
//   AW_DEF  : default address width
//   DW_DEF  : default data width
package pkg_6502;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/clk0_edge.sv
// clk0 edge detector: compares clk0 with a copy registered on eclk, so each
// clk0 edge is reported one eclk after it occurs.
//   eclk, ereset_n : system clock, asynchronous active-low reset
//   clk0           : 6502 phase clock (synchronous to eclk)
//   rise, fall     : single-eclk edge pulses
module clk0_edge (
  input  logic eclk,
  input  logic ereset_n,
  input  logic clk0,
  output logic rise,
  output logic fall
);

  logic clk0_d;

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) clk0_d <= 1'b0;
    else           clk0_d <= clk0;
  end

  assign rise = clk0 & ~clk0_d;
  assign fall = ~clk0 & clk0_d;

endmodule

// File: rtl/bus_6502.sv
// Bridge from a 6502 core bus to a request/acknowledge memory bus.
// One memory access is launched per clk0 (phi2) rise while the core runs.
//   eclk, ereset_n          : system clock, asynchronous active-low reset
//   clk0, res               : phase clock, core run (active-high run)
//   ab, rw, db_out, db_in   : core address, read strobe, write/read data
//   mem_req .. mem_rdata    : memory request/acknowledge bus
//   cycle_cnt, drop_cnt     : issued / dropped bus cycle counters
//   overrun                 : sticky late-acknowledge flag
module bus_6502
  import pkg_6502::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          eclk,
  input  logic          ereset_n,
  input  logic          clk0,
  input  logic          res,
  input  logic [AW-1:0] ab,
  input  logic          rw,
  input  logic [DW-1:0] db_out,
  output logic [DW-1:0] db_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   cycle_cnt,
  output logic          overrun,
  output logic [7:0]    drop_cnt
);

  state_t      state, state_n;
  logic        rise, fall;
  logic        late;      // current access missed its clk0 fall
  logic        start, take_ack, drop, miss;
  logic [31:0] cycle_q;

  assign cycle_cnt = cycle_q;

  clk0_edge u_edge (
    .eclk     (eclk),
    .ereset_n (ereset_n),
    .clk0     (clk0),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    take_ack = 1'b0;
    drop     = 1'b0;
    miss     = 1'b0;
    case (state)
      IDLE: begin
        if (rise && res) begin
          start   = 1'b1;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (rise && res) drop = 1'b1;
        if (mem_ack) begin
          take_ack = 1'b1;
          // An ack coinciding with the fall, or arriving after a missed
          // fall, leaves nothing to wait for in DONE.
          state_n  = (fall || late) ? IDLE : DONE;
        end else if (fall) begin
          miss = 1'b1;
        end
      end
      DONE: begin
        if (rise && res) drop = 1'b1;
        if (fall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      db_in     <= '0;
      cycle_q   <= '0;
      drop_cnt  <= '0;
      overrun   <= 1'b0;
      late      <= 1'b0;
    end else begin
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= ~rw;
        mem_addr  <= ab;
        mem_wdata <= db_out;
        cycle_q   <= cycle_q + 32'd1;
        late      <= 1'b0;
      end
      if (take_ack) begin
        mem_req <= 1'b0;
        if (!mem_we) db_in <= mem_rdata;
      end
      if (miss) begin
        overrun <= 1'b1;
        late    <= 1'b1;
      end
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_6502.sv
module tb_bus_6502;
  import pkg_6502::*;

  logic        eclk, ereset_n, clk0, res, rw;
  logic [15:0] ab, mem_addr;
  logic [7:0]  db_out, db_in, mem_wdata, mem_rdata, drop_cnt;
  logic        mem_req, mem_we, mem_ack, overrun;
  logic [31:0] cycle_cnt;

  bus_6502 #(.AW(16), .DW(8)) dut (
    .eclk(eclk), .ereset_n(ereset_n), .clk0(clk0), .res(res),
    .ab(ab), .rw(rw), .db_out(db_out), .db_in(db_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cycle_cnt(cycle_cnt), .overrun(overrun), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [31:0] cnt;
  } acc_t;

  acc_t        exp_acc[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  mem_model[logic [15:0]];
  logic [7:0]  model_db;
  logic [31:0] cnt_model;
  int          checks, failures;
  int          ack_delay, wait_cnt;
  bit          hold_ack;

  initial begin
    eclk = 1'b0;
    forever #5 eclk = ~eclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge eclk);
  endtask

  // Raise clk0 with a new core bus cycle presented; record the access the
  // core bus should launch if the bridge is free and the core runs.
  task automatic raise(input logic [15:0] a, input logic r, input logic [7:0] d, input bit expect_issue);
    acc_t e;
    ab = a; rw = r; db_out = d; clk0 = 1'b1;
    if (expect_issue) begin
      cnt_model = cnt_model + 32'd1;
      e.addr = a; e.we = ~r; e.wdata = d; e.cnt = cnt_model;
      exp_acc.push_back(e);
    end
  endtask

  task automatic period(input logic [15:0] a, input logic r, input logic [7:0] d,
                        input bit expect_issue, input int hi, input int lo);
    raise(a, r, d, expect_issue);
    tick(hi);
    clk0 = 1'b0;
    tick(lo);
  endtask

  // Memory responder: acks after ack_delay eclk of mem_req, backed by a
  // byte-addressed memory model.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; wait_cnt = 0;
    forever begin
      @(negedge eclk); #1;
      if (!ereset_n) begin
        mem_ack = 1'b0; wait_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0; wait_cnt = 0;
      end else if (mem_req) begin
        wait_cnt++;
        if (!hold_ack && wait_cnt >= ack_delay) begin
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = 8'($urandom);
          end else begin
            if (!mem_model.exists(mem_addr)) mem_model[mem_addr] = 8'($urandom);
            model_db = mem_model[mem_addr];
            mem_rdata = model_db;
          end
          exp_rd.push_back(model_db);
          mem_ack = 1'b1;
        end
      end
    end
  end

  // Monitor: checks every launched access and the read data left after it.
  initial begin
    bit   prev;
    acc_t held;
    prev = 1'b0;
    held = '{default: '0};
    forever begin
      @(negedge eclk); #2;
      if (!ereset_n) begin
        prev = 1'b0;
      end else begin
        if (mem_req && !prev) begin
          if (exp_acc.size() == 0) begin
            check("unexpected_req", 32'(mem_req), 32'd0);
          end else begin
            held = exp_acc.pop_front();
            check("mem_addr", 32'(mem_addr), 32'(held.addr));
            check("mem_we", 32'(mem_we), 32'(held.we));
            check("mem_wdata", 32'(mem_wdata), 32'(held.wdata));
            check("cycle_cnt", cycle_cnt, held.cnt);
          end
        end else if (mem_req && prev) begin
          check("hold_addr", 32'(mem_addr), 32'(held.addr));
          check("hold_we", 32'(mem_we), 32'(held.we));
          check("hold_wdata", 32'(mem_wdata), 32'(held.wdata));
        end
        if (!mem_req && prev) begin
          if (exp_rd.size() == 0) check("req_drop_without_ack", 32'(mem_req), 32'd1);
          else check("db_in", 32'(db_in), 32'(exp_rd.pop_front()));
        end
        prev = mem_req;
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    cnt_model = '0; model_db = '0;
    hold_ack = 1'b0; ack_delay = 1;
    ereset_n = 1'b0; clk0 = 1'b0; res = 1'b1;
    ab = '0; rw = 1'b1; db_out = '0;
    tick(2);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_db_in", 32'(db_in), 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    #3 ereset_n = 1'b1;
    tick(2);

    // Read of the reset vector, ack 3 eclk after the request.
    mem_model[16'hFFFC] = 8'h34;
    ack_delay = 3;
    period(16'hFFFC, 1'b1, 8'h00, 1'b1, 4, 4);
    check("read_db_in", 32'(db_in), 32'h34);
    check("read_cycle_cnt", cycle_cnt, 32'd1);
    check("read_overrun", 32'(overrun), 32'd0);

    // Write; res drops mid-access and the handshake still completes.
    ack_delay = 2;
    raise(16'h0200, 1'b0, 8'hA5, 1'b1);
    tick(1); res = 1'b0;
    tick(3); clk0 = 1'b0;
    tick(4); res = 1'b1;
    check("write_db_in_kept", 32'(db_in), 32'h34);
    check("write_state_idle", 32'(dut.state), 32'(IDLE));
    check("write_mem", 32'(mem_model[16'h0200]), 32'hA5);

    // Ack in the same eclk as the detected clk0 fall.
    ack_delay = 4;
    period(16'h0200, 1'b1, 8'h00, 1'b1, 4, 4);
    check("same_cycle_overrun", 32'(overrun), 32'd0);
    check("same_cycle_state", 32'(dut.state), 32'(IDLE));
    check("same_cycle_db_in", 32'(db_in), 32'hA5);

    // Late ack: fall passes without ack, next rise is dropped.
    ack_delay = 1; hold_ack = 1'b1;
    period(16'h1234, 1'b1, 8'h00, 1'b1, 4, 4);
    check("late_overrun", 32'(overrun), 32'd1);
    period(16'h5678, 1'b1, 8'h00, 1'b0, 4, 4);
    check("late_drop_cnt", 32'(drop_cnt), 32'd1);
    check("late_cycle_cnt", cycle_cnt, 32'd4);
    hold_ack = 1'b0;
    tick(3);
    check("late_state_idle", 32'(dut.state), 32'(IDLE));
    period(16'h4000, 1'b0, 8'h5A, 1'b1, 4, 4);
    check("after_late_cycle_cnt", cycle_cnt, 32'd5);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset mid-WAIT_ACK.
    hold_ack = 1'b1;
    raise(16'h0300, 1'b1, 8'h00, 1'b1);
    tick(2);
    #3 ereset_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_db_in", 32'(db_in), 32'd0);
    check("arst_cycle_cnt", cycle_cnt, 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    cnt_model = '0; model_db = '0;
    clk0 = 1'b0; hold_ack = 1'b0;
    tick(2);
    #3 ereset_n = 1'b1;
    tick(1);

    // Core held in reset for 10 clk0 periods.
    res = 1'b0;
    for (int i = 0; i < 10; i++)
      period(16'($urandom), 1'($urandom), 8'($urandom), 1'b0, 4, 4);
    check("res0_cycle_cnt", cycle_cnt, 32'd0);
    check("res0_drop_cnt", 32'(drop_cnt), 32'd0);
    check("res0_mem_req", 32'(mem_req), 32'd0);

    // Random traffic, every access completes inside its phi2.
    for (int i = 0; i < 60; i++) begin
      res = ($urandom_range(3) != 0);
      ack_delay = $urandom_range(3, 1);
      period(16'($urandom), 1'($urandom), 8'($urandom), bit'(res), 4, 4);
    end
    res = 1'b1;
    tick(4);
    check("rand_cycle_cnt", cycle_cnt, cnt_model);
    check("rand_drop_cnt", 32'(drop_cnt), 32'd0);

    // drop_cnt saturation.
    hold_ack = 1'b1; ack_delay = 1;
    period(16'h0400, 1'b1, 8'h00, 1'b1, 2, 2);
    for (int i = 1; i <= 300; i++) begin
      period(16'($urandom), 1'b1, 8'h00, 1'b0, 2, 2);
      if (i == 200) check("drop_cnt_200", 32'(drop_cnt), 32'd200);
    end
    check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
    hold_ack = 1'b0;
    tick(4);

    // cycle_cnt wrap.
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_q;
    cnt_model = 32'hFFFF_FFFF;
    tick(1);
    period(16'h0500, 1'b0, 8'h11, 1'b1, 4, 4);
    check("cycle_cnt_wrap", cycle_cnt, 32'd0);
    check("drop_cnt_hold", 32'(drop_cnt), 32'd255);

    tick(4);
    check("exp_acc_empty", 32'(exp_acc.size()), 32'd0);
    check("exp_rd_empty", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
